// File: rtl/discrete_range_sequencer_if.sv
// Request/result and table-read signals of the discrete range sequencer.
// The master side issues requests and serves the table; the slave side is the sequencer.
interface discrete_range_sequencer_if #(
  parameter int W = 8,
  parameter int V = 8,
  parameter int C = 4
);
  logic         in_start;
  logic [V-1:0] in_variable_index;
  logic [C-1:0] in_number_of_choices_minus_one;
  logic [W-1:0] in_random;
  logic [V-1:0] out_table_variable_index;
  logic [C-1:0] out_table_choice_index;
  logic [W-1:0] in_table_start;
  logic [W-1:0] in_table_end;
  logic [W-1:0] out_value;
  logic         out_valid;
  logic         out_busy;
  logic         out_error;

  modport master (
    output in_start, in_variable_index, in_number_of_choices_minus_one, in_random,
    output in_table_start, in_table_end,
    input  out_table_variable_index, out_table_choice_index,
    input  out_value, out_valid, out_busy, out_error
  );

  modport slave (
    input  in_start, in_variable_index, in_number_of_choices_minus_one, in_random,
    input  in_table_start, in_table_end,
    output out_table_variable_index, out_table_choice_index,
    output out_value, out_valid, out_busy, out_error
  );
endinterface

// File: rtl/discrete_range_sequencer.sv
// Picks a random choice for a variable by rejection sampling, reads its [start,end]
// range from an external table, then rejection-samples a uniform value inside that range.
module discrete_range_sequencer #(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
  parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4,
  parameter int MAX_RETRIES                       = 16
) (
  input logic                     clk,
  input logic                     reset,
  discrete_range_sequencer_if.slave bus
);
  localparam int W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int V  = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
  localparam int C  = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    IDLE,
    PICK_CHOICE,
    READ_TABLE,
    PICK_VALUE,
    DONE
  } state_t;

  // Smallest all-ones mask covering x: smear every set bit towards the LSB.
  function automatic logic [W-1:0] fill_w(input logic [W-1:0] x);
    logic [W-1:0] m;
    m = x;
    for (int i = 1; i < W; i++) m = m | (x >> i);
    return m;
  endfunction

  function automatic logic [C-1:0] fill_c(input logic [C-1:0] x);
    logic [C-1:0] m;
    m = x;
    for (int i = 1; i < C; i++) m = m | (x >> i);
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [V-1:0]  var_q, var_d;
  logic [C-1:0]  nchoice_q, nchoice_d;
  logic [C-1:0]  choice_q, choice_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic [W-1:0]  start_q, start_d;
  logic [W-1:0]  end_q, end_d;
  logic [W-1:0]  value_q, value_d;
  logic          valid_q, valid_d;
  logic          err_out_q, err_out_d;

  logic [C-1:0]  cand;
  logic [W-1:0]  span;
  logic [W-1:0]  offset;
  logic          retry_last;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    var_d      = var_q;
    nchoice_d  = nchoice_q;
    choice_d   = choice_q;
    retry_d    = retry_q;
    err_d      = err_q;
    start_d    = start_q;
    end_d      = end_q;
    value_d    = value_q;
    err_out_d  = err_out_q;
    valid_d    = (state_q == DONE);

    cand       = bus.in_random[C-1:0] & fill_c(nchoice_q);
    span       = end_q - start_q;
    offset     = bus.in_random & fill_w(span);
    retry_last = (retry_q == RW'(MAX_RETRIES - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.in_start) begin
          var_d     = bus.in_variable_index;
          nchoice_d = bus.in_number_of_choices_minus_one;
          retry_d   = '0;
          err_d     = 1'b0;
          err_out_d = 1'b0;
          state_d   = PICK_CHOICE;
        end
      end
      PICK_CHOICE: begin
        if (cand <= nchoice_q) begin
          choice_d = cand;
          retry_d  = '0;
          state_d  = READ_TABLE;
        end else if (retry_last) begin
          // Give up on the choice but still produce a value from choice 0.
          choice_d = '0;
          err_d    = 1'b1;
          retry_d  = '0;
          state_d  = READ_TABLE;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      READ_TABLE: begin
        start_d = bus.in_table_start;
        end_d   = bus.in_table_end;
        if (bus.in_table_start > bus.in_table_end) begin
          value_d = bus.in_table_start;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = PICK_VALUE;
        end
      end
      PICK_VALUE: begin
        if (offset <= span) begin
          value_d = start_q + offset;
          state_d = DONE;
        end else if (retry_last) begin
          value_d = start_q;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      DONE: begin
        err_out_d = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      var_q     <= '0;
      nchoice_q <= '0;
      choice_q  <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      var_q     <= var_d;
      nchoice_q <= nchoice_d;
      choice_q  <= choice_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      start_q   <= start_d;
      end_q     <= end_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      err_out_q <= err_out_d;
    end
  end

  // Result flags are registered out of DONE, so they appear one cycle after it.
  assign bus.out_table_variable_index = var_q;
  assign bus.out_table_choice_index   = choice_q;
  assign bus.out_value                = value_q;
  assign bus.out_valid                = valid_q;
  assign bus.out_error                = err_out_q;
  assign bus.out_busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_discrete_range_sequencer.sv
// Table-driven bench with a scoreboard of expected results, plus hand-written
// reset and busy-ignore sequences.
module tb_discrete_range_sequencer;
  localparam int W = 8;
  localparam int V = 8;
  localparam int C = 4;

  typedef struct packed {
    logic [7:0]      vidx;
    logic [3:0]      nc;
    logic [7:0]      ts;
    logic [7:0]      te;
    logic [5:0][7:0] rnd;
    logic [31:0]     nrnd;
    logic [7:0]      fill;
    logic [7:0]      ev;
    logic            ee;
    logic [3:0]      ec;
    logic [31:0]     lat;
    logic            busy_start;
  } vec_t;

  typedef struct packed {
    logic [7:0]  value;
    logic        error;
    logic [7:0]  vidx;
    logic [3:0]  cidx;
    logic [31:0] lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  discrete_range_sequencer_if #(.W(W), .V(V), .C(C)) bus ();
  discrete_range_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] tbl_s [256][16];
  logic [7:0] tbl_e [256][16];
  assign bus.in_table_start = tbl_s[bus.out_table_variable_index][bus.out_table_choice_index];
  assign bus.in_table_end   = tbl_e[bus.out_table_variable_index][bus.out_table_choice_index];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] vidx, input logic [3:0] nc,
                              input logic [7:0] ts, input logic [7:0] te,
                              input logic [47:0] rnd, input int nrnd, input logic [7:0] fill,
                              input logic [7:0] ev, input logic ee, input logic [3:0] ec,
                              input int lat, input logic bs);
    vec_t v;
    v.vidx = vidx; v.nc = nc; v.ts = ts; v.te = te; v.rnd = rnd; v.nrnd = nrnd;
    v.fill = fill; v.ev = ev; v.ee = ee; v.ec = ec; v.lat = lat; v.busy_start = bs;
    return v;
  endfunction

  // Called at a falling edge; in_start is sampled at the next rising edge (E0).
  task automatic run_vec(input vec_t v);
    exp_t            e;
    bit              seen;
    logic [5:0][7:0] r;
    r = v.rnd;
    for (int c = 0; c < 16; c++) begin
      tbl_s[v.vidx][c] = 8'hEE;
      tbl_e[v.vidx][c] = 8'hEE;
    end
    tbl_s[v.vidx][v.ec] = v.ts;
    tbl_e[v.vidx][v.ec] = v.te;
    e.value = v.ev; e.error = v.ee; e.vidx = v.vidx; e.cidx = v.ec; e.lat = v.lat;
    sb.push_back(e);

    bus.in_start                       = 1'b1;
    bus.in_variable_index              = v.vidx;
    bus.in_number_of_choices_minus_one = v.nc;
    bus.in_random                      = v.fill;
    @(negedge clk);
    bus.in_start  = 1'b0;
    bus.in_random = (v.nrnd > 0) ? r[0] : v.fill;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        bus.in_start = 1'b0;
        seen = 1'b1;
        e = sb.pop_front();
        check("value",    32'(bus.out_value), 32'(e.value));
        check("error",    32'(bus.out_error), 32'(e.error));
        check("var_addr", 32'(bus.out_table_variable_index), 32'(e.vidx));
        check("choice",   32'(bus.out_table_choice_index), 32'(e.cidx));
        check("latency",  32'(k), e.lat);
      end else begin
        bus.in_random = (k < int'(v.nrnd)) ? r[k] : v.fill;
        if (v.busy_start) begin
          bus.in_start          = (k == 1 || k == 2);
          bus.in_variable_index = 8'd5;
        end
      end
    end
    check("valid_seen", 32'(seen), 32'd1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    check("valid_pulse", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 16; j++) begin
        tbl_s[i][j] = 8'h00;
        tbl_e[i][j] = 8'h00;
      end
    bus.in_start                       = 1'b0;
    bus.in_variable_index              = '0;
    bus.in_number_of_choices_minus_one = '0;
    bus.in_random                      = '0;

    //          var    nc     start   end     rnd r5..r0                                    n  fill   val    err  ch     lat bs
    vecs[0] = mk(8'd3, 4'd0,  8'd5,   8'd5,   48'h0,                                         0, 8'hA7, 8'd5,   0, 4'd0,  4,  0);
    vecs[1] = mk(8'd1, 4'd2,  8'd9,   8'd9,   48'h0,                                         0, 8'h03, 8'd9,   1, 4'd0,  19, 0);
    vecs[2] = mk(8'd7, 4'd2,  8'd20,  8'd27,  {8'h00, 8'h05, 8'hFF, 8'hC1, 8'h13, 8'hF3},    5, 8'h00, 8'd25,  0, 4'd1,  6,  0);
    vecs[3] = mk(8'd2, 4'd0,  8'd40,  8'd10,  48'h0,                                         0, 8'h00, 8'd40,  1, 4'd0,  3,  1);
    vecs[4] = mk(8'd10, 4'd0, 8'd100, 8'd200, {8'h00, 8'h00, 8'hB2, 8'h78, 8'h00, 8'h00},    4, 8'h00, 8'd150, 0, 4'd0,  5,  0);
    vecs[5] = mk(8'd6, 4'd1,  8'd3,   8'd131, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01},    1, 8'hFF, 8'd3,   1, 4'd1,  19, 0);
    vecs[6] = mk(8'd4, 4'd15, 8'd0,   8'd255, {8'h00, 8'h00, 8'h00, 8'hAB, 8'h00, 8'hCF},    3, 8'h00, 8'hAB,  0, 4'd15, 4,  0);
    vecs[7] = mk(8'd9, 4'd4,  8'd250, 8'd255, {8'h00, 8'h0D, 8'h07, 8'h00, 8'h04, 8'h06},    5, 8'h00, 8'd255, 0, 4'd4,  6,  0);

    @(negedge clk);
    check("rst_value",  32'(bus.out_value), 32'd0);
    check("rst_valid",  32'(bus.out_valid), 32'd0);
    check("rst_busy",   32'(bus.out_busy), 32'd0);
    check("rst_error",  32'(bus.out_error), 32'd0);
    check("rst_var",    32'(bus.out_table_variable_index), 32'd0);
    check("rst_choice", 32'(bus.out_table_choice_index), 32'd0);

    // Release reset and request in the same cycle: the first edge must take it.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].busy_start) begin
        repeat (2) begin
          @(negedge clk);
          check("ignored_busy",  32'(bus.out_busy), 32'd0);
          check("ignored_valid", 32'(bus.out_valid), 32'd0);
        end
      end
    end

    // Reset landing between edges while the value phase is rejecting.
    for (int c = 0; c < 16; c++) begin
      tbl_s[12][c] = 8'd3;
      tbl_e[12][c] = 8'd131;
    end
    bus.in_start                       = 1'b1;
    bus.in_variable_index              = 8'd12;
    bus.in_number_of_choices_minus_one = 4'd0;
    bus.in_random                      = 8'hFF;
    @(negedge clk);
    bus.in_start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(bus.out_busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_value",  32'(bus.out_value), 32'd0);
    check("async_valid",  32'(bus.out_valid), 32'd0);
    check("async_busy",   32'(bus.out_busy), 32'd0);
    check("async_error",  32'(bus.out_error), 32'd0);
    check("async_var",    32'(bus.out_table_variable_index), 32'd0);
    check("async_choice", 32'(bus.out_table_choice_index), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    end
    reset = 1'b0;
    run_vec(mk(8'd8, 4'd0, 8'd77, 8'd77, 48'h0, 0, 8'h00, 8'd77, 0, 4'd0, 4, 0));

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
